// File: rtl/seq_scan_pkg.sv
// Shared widths, lengths and controller state encoding for the sequence scan controller.
package seq_scan_pkg;

    localparam int unsigned WordW    = 8;
    localparam int unsigned CntW     = 16;
    localparam int unsigned ShiftLen = 8;
    localparam int unsigned IdxW     = 3;
    localparam int unsigned PosW     = 3;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFlush0 = 3'd1,
        StFlush1 = 3'd2,
        StShift  = 3'd3,
        StDrain  = 3'd4,
        StReport = 3'd5
    } state_e;

endpackage

// File: rtl/sequence_detector.sv
// Serial detector for 0101 / 0110; out is registered and held high for two cycles per match.
// While out is held the input is ignored, and two zeros in a row restart the search.
module sequence_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic seq,
    output logic out
);

    typedef enum logic [2:0] {
        StNone = 3'd0,
        StZ    = 3'd1,
        StZO   = 3'd2,
        StZOZ  = 3'd3,
        StZOO  = 3'd4,
        StHit1 = 3'd5,
        StHit2 = 3'd6
    } det_state_e;

    det_state_e r_state;
    det_state_e w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StNone:  w_state_nxt = seq ? StNone : StZ;
            StZ:     w_state_nxt = seq ? StZO : StNone;
            StZO:    w_state_nxt = seq ? StZOO : StZOZ;
            StZOZ:   w_state_nxt = seq ? StHit1 : StNone;
            StZOO:   w_state_nxt = seq ? StNone : StHit1;
            StHit1:  w_state_nxt = StHit2;
            StHit2:  w_state_nxt = StNone;
            default: w_state_nxt = StNone;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StNone;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign out = (r_state == StHit1) || (r_state == StHit2);

endmodule

// File: rtl/seq_scan_ctrl.sv
// Feeds one captured word MSB-first through a freshly reset sequence_detector and reports
// whether (and at which bit) the first match completed, plus a saturating hit counter.
module seq_scan_ctrl
    import seq_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WordW-1:0] in_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_hit,
    output logic [PosW-1:0]  res_pos,
    output logic [CntW-1:0]  hit_cnt,
    input  logic             cnt_clr,
    output logic             busy
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [WordW-1:0]  r_shift;
    logic [IdxW-1:0]   r_idx;
    logic              r_det_rst_n;
    logic              r_out_q;
    logic              r_hit;
    logic [PosW-1:0]   r_pos;
    logic [CntW-1:0]   r_hit_cnt;

    logic              w_in_fire;
    logic              w_det_rst_n;
    logic              w_det_seq;
    logic              w_det_out;
    logic              w_rise;
    logic              w_rec;
    logic [PosW-1:0]   w_rec_pos;
    logic              w_inc;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:   if (in_valid) w_state_nxt = StFlush0;
            StFlush0: w_state_nxt = StFlush1;
            StFlush1: w_state_nxt = StShift;
            StShift:  if (r_idx == IdxW'(ShiftLen - 1)) w_state_nxt = StDrain;
            StDrain:  w_state_nxt = StReport;
            StReport: if (res_ready) w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    assign w_in_fire   = (r_state == StIdle) && in_valid;
    assign w_det_rst_n = r_det_rst_n & rst_n;
    // Idle-high input keeps the detector out of any partial match outside SHIFT.
    assign w_det_seq   = (r_state == StShift) ? r_shift[WordW-1] : 1'b1;

    // Detector output lags its input by one cycle, so a rise names the previous bit.
    assign w_rise    = w_det_out & ~r_out_q;
    assign w_rec     = w_rise & ~r_hit &
                       (((r_state == StShift) && (r_idx != '0)) || (r_state == StDrain));
    assign w_rec_pos = (r_state == StDrain) ? PosW'(ShiftLen - 1) : (r_idx - IdxW'(1));
    assign w_inc     = (r_state == StDrain) && (r_hit || w_rec) && (r_hit_cnt != '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_shift     <= '0;
            r_idx       <= '0;
            r_det_rst_n <= 1'b0;
            r_out_q     <= 1'b0;
            r_hit       <= 1'b0;
            r_pos       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_det_rst_n <= (w_state_nxt != StFlush0);
            r_out_q     <= w_det_out;
            if (w_in_fire) begin
                r_shift <= in_data;
                r_idx   <= '0;
                r_hit   <= 1'b0;
                r_pos   <= '0;
            end else begin
                if (r_state == StShift) begin
                    r_shift <= r_shift << 1;
                    r_idx   <= r_idx + IdxW'(1);
                end
                if (w_rec) begin
                    r_hit <= 1'b1;
                    r_pos <= w_rec_pos;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt <= '0;
        end else if (cnt_clr) begin
            r_hit_cnt <= '0;
        end else if (w_inc) begin
            r_hit_cnt <= r_hit_cnt + CntW'(1);
        end
    end

    sequence_detector u_det (
        .clk   (clk),
        .rst_n (w_det_rst_n),
        .seq   (w_det_seq),
        .out   (w_det_out)
    );

    assign in_ready  = (r_state == StIdle);
    assign busy      = (r_state != StIdle);
    assign res_valid = (r_state == StReport);
    assign res_hit   = res_valid & r_hit;
    assign res_pos   = (res_valid && r_hit) ? r_pos : '0;
    assign hit_cnt   = r_hit_cnt;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench: the driver queues hand-computed results, a monitor checks each report.
module tb_seq_scan_ctrl;

    typedef struct {
        logic        hit;
        logic [2:0]  pos;
        logic [15:0] cnt;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        res_ready = 1'b1;
    logic        cnt_clr = 1'b0;
    logic        in_ready;
    logic        res_valid;
    logic        res_hit;
    logic [2:0]  res_pos;
    logic [15:0] hit_cnt;
    logic        busy;

    exp_t        sb[$];
    logic [15:0] m_cnt = 16'h0000;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_rise = 0;

    seq_scan_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_hit   (res_hit),
        .res_pos   (res_pos),
        .hit_cnt   (hit_cnt),
        .cnt_clr   (cnt_clr),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic send(input logic [7:0] d, input logic eh, input logic [2:0] ep,
                        input logic clr, input bit push, output int c0);
        int   n;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        c0 = cyc;
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            if (clr) m_cnt = 16'h0000;
            else if (eh && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
            e.hit = eh;
            e.pos = ep;
            e.cnt = m_cnt;
            e.t   = c0 + 12;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;
        if (clr) begin
            // Land the clear on the DRAIN->REPORT edge, together with the increment.
            repeat (10) @(negedge clk);
            cnt_clr = 1'b1;
            @(negedge clk);
            cnt_clr = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: pending %0d results, in_ready %0b", sb.size(), in_ready);
        end
    endtask

    initial begin : monitor
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (res_valid && !prev_v) begin
                    n_rise++;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_result: res_valid=1 with nothing queued");
                    end else begin
                        e = sb.pop_front();
                        chk("res_hit", 32'(res_hit), 32'(e.hit));
                        chk("res_pos", 32'(res_pos), 32'(e.pos));
                        chk("hit_cnt", 32'(hit_cnt), 32'(e.cnt));
                        chk("res_valid_cycle", 32'(cyc), 32'(e.t));
                    end
                end
                prev_v = res_valid;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int c0a;
        int c0b;
        int r0;
        int n;

        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_hit", 32'(res_hit), 32'd0);
        chk("rst_res_pos", 32'(res_pos), 32'd0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_res_valid", 32'(res_valid), 32'd0);
        chk("rel_busy", 32'(busy), 32'd0);

        send(8'b0101_0000, 1'b1, 3'd3, 1'b0, 1'b1, c0a);
        wait_idle();
        send(8'b1111_0110, 1'b1, 3'd7, 1'b0, 1'b1, c0a);
        wait_idle();
        send(8'b1110_0110, 1'b0, 3'd0, 1'b0, 1'b1, c0a);
        wait_idle();

        // Reset during SHIFT index 4: word is dropped, counter cleared.
        send(8'b1011_0100, 1'b1, 3'd4, 1'b0, 1'b0, c0a);
        repeat (6) @(negedge clk);
        chk("midop_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_res_hit", 32'(res_hit), 32'd0);
        chk("midrst_res_pos", 32'(res_pos), 32'd0);
        chk("midrst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        m_cnt = 16'h0000;
        r0 = n_rise;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrel_in_ready", 32'(in_ready), 32'd1);
        chk("midrel_busy", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        chk("no_result_after_reset", 32'(n_rise), 32'(r0));

        send(8'b0101_0101, 1'b1, 3'd3, 1'b0, 1'b1, c0a);
        send(8'b0101_0101, 1'b1, 3'd3, 1'b0, 1'b1, c0b);
        chk("accept_period", 32'(c0b - c0a), 32'd13);
        wait_idle();

        // Consumer stalls for five REPORT cycles.
        res_ready = 1'b0;
        send(8'b1011_0100, 1'b1, 3'd4, 1'b0, 1'b1, c0a);
        n = 0;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reached", 32'(res_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(res_valid), 32'd1);
            chk("stall_hit", 32'(res_hit), 32'd1);
            chk("stall_pos", 32'(res_pos), 32'd4);
            chk("stall_cnt", 32'(hit_cnt), 32'(m_cnt));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("ack_in_ready", 32'(in_ready), 32'd1);
        chk("ack_res_valid", 32'(res_valid), 32'd0);

        // Saturation and clear-over-increment.
        @(negedge clk);
        force dut.r_hit_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.r_hit_cnt;
        m_cnt = 16'hFFFE;
        #1;
        chk("preload_cnt", 32'(hit_cnt), 32'h0000FFFE);
        send(8'b1101_0110, 1'b1, 3'd5, 1'b0, 1'b1, c0a);
        wait_idle();
        send(8'b1110_1010, 1'b1, 3'd6, 1'b0, 1'b1, c0a);
        wait_idle();
        send(8'b0101_0000, 1'b1, 3'd3, 1'b1, 1'b1, c0a);
        wait_idle();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
